// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// default bit timing. The receiver imports the same package so both ends
// agree on the encoding.
package uart_tx_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  // 12 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and raises a
// registered one-clk tick on the last cycle of each bit period. Parked at 0
// while disabled, so every frame starts phase-aligned to its start bit.
module uart_baud_tick
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next count: restart on clear, wrap after the last cycle, hold at 0 when idle
  always_comb begin
    cnt_nxt = '0;
    if (clear) begin
      cnt_nxt = '0;
    end else if (enable) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // The tick is registered from the next count so it lines up with the cycle
  // in which the counter actually holds LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= enable && (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one parallel word per valid/ready handshake, sent as
// start bit, LSB-first data, then STOP_BITS stop bits. All outputs are
// registered; only reset acts asynchronously.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line at mark, tx_ready high, waiting for tx_valid
// ST_START | start bit (tx=0) for one bit period
// ST_DATA  | tx=shift[0], shift right at the end of each bit period
// ST_STOP  | stop bit(s) (tx=1) for STOP_BITS bit periods
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 baud
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] SAT_BIT   = IW'(DATA_BITS);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [IW-1:0]        bit_idx;
  logic [IW-1:0]        bit_idx_nxt;
  logic                 stop_idx;
  logic                 stop_idx_nxt;
  logic                 tx_nxt;
  logic                 handshake;
  logic                 bit_end;
  logic                 timer_en;

  assign handshake = tx_valid && tx_ready;
  // baud is high exactly on the last cycle of every non-idle bit period
  assign bit_end   = baud;
  assign timer_en  = (state_nxt != ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (handshake),
    .enable(timer_en),
    .tick  (baud)
  );

  // Next-state, shift register, bit/stop index and line value
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;

    case (state)
      ST_IDLE: begin
        if (handshake) begin
          state_nxt    = ST_START;
          shift_nxt    = tx_data;
          bit_idx_nxt  = '0;
          stop_idx_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_nxt = shift >> 1;
          if (bit_idx != SAT_BIT) begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
          if (bit_idx == LAST_BIT) begin
            state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx == LAST_STOP) begin
            state_nxt = ST_IDLE;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Line value follows the state being entered so tx is a plain register
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shift_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame and returns the line to mark
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      tx       <= tx_nxt;
      tx_ready <= (state_nxt == ST_IDLE);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast instance (4 clks/bit, 1 stop bit) for frame
// timing, back-to-back, data-hold and reset cases, and a 104 clks/bit,
// 2-stop-bit instance looped into a mid-bit sampling receiver model.
module tb_uart_tx;

  localparam int CPB      = 4;
  localparam int FRAME    = (1 + 8 + 1) * CPB;
  localparam int LB_CPB   = 104;
  localparam int LB_FRAME = (1 + 8 + 2) * LB_CPB;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       baud;

  logic [7:0] lb_tx_data;
  logic       lb_tx_valid;
  logic       lb_tx_ready;
  logic       lb_tx;
  logic       lb_busy;
  logic       lb_baud;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy),
    .baud    (baud)
  );

  uart_tx #(.CLKS_PER_BIT(LB_CPB), .DATA_BITS(8), .STOP_BITS(2)) dut_lb (
    .clk     (clk),
    .reset   (reset),
    .tx_data (lb_tx_data),
    .tx_valid(lb_tx_valid),
    .tx_ready(lb_tx_ready),
    .tx      (lb_tx),
    .busy    (lb_busy),
    .baud    (lb_baud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level in cycle i of a frame carrying d (1 stop bit)
  function automatic logic line_bit(input logic [7:0] d, input int i);
    int bp;
    bp = i / CPB;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return d[bp-1];
    return 1'b1;
  endfunction

  // Called at a negedge with the fast DUT idle. Sends d, checks every cycle of
  // the frame and the single idle cycle that follows it.
  task automatic run_frame(input string tag, input logic [7:0] d, input bit keep_valid,
                           input int change_at, input logic [7:0] alt);
    int bad_tx;
    int bad_baud;
    int pulses;
    int ready_low;
    bad_tx = 0;
    bad_baud = 0;
    pulses = 0;
    ready_low = 0;
    check({tag, "_ready_before"}, {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = keep_valid;
    for (int i = 0; i < FRAME; i++) begin
      if (tx !== line_bit(d, i)) bad_tx++;
      if (baud !== ((i % CPB) == CPB - 1)) bad_baud++;
      if (baud === 1'b1) pulses++;
      if (tx_ready === 1'b0 && busy === 1'b1) ready_low++;
      if (i == change_at) tx_data = alt;
      @(negedge clk);
    end
    check({tag, "_tx_pattern_errs"}, bad_tx, 0);
    check({tag, "_baud_pos_errs"}, bad_baud, 0);
    check({tag, "_baud_pulses"}, pulses, 10);
    check({tag, "_busy_clks"}, ready_low, FRAME);
    check({tag, "_idle_after"}, {28'd0, tx, tx_ready, busy, baud}, 32'hC);
  endtask

  // Loopback receiver model: finds the start edge, samples mid-bit, and
  // measures how long busy stays high.
  task automatic lb_frame(input string tag, input logic [7:0] d);
    int w;
    int len;
    logic [10:0] bits;
    bits = '0;
    check({tag, "_ready_before"}, {31'd0, lb_tx_ready}, 32'd1);
    lb_tx_data  = d;
    lb_tx_valid = 1'b1;
    @(negedge clk);
    lb_tx_valid = 1'b0;
    w = 0;
    while (lb_tx !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_start_seen"}, {31'd0, (w < 20)}, 32'd1);
    len = 0;
    while (lb_busy === 1'b1 && len < 3000) begin
      if ((len % LB_CPB) == LB_CPB / 2 && (len / LB_CPB) < 11) bits[len / LB_CPB] = lb_tx;
      len++;
      @(negedge clk);
    end
    check({tag, "_frame_clks"}, len, LB_FRAME);
    check({tag, "_start_bit"}, {31'd0, bits[0]}, 32'd0);
    check({tag, "_rx_byte"}, {24'd0, bits[8:1]}, {24'd0, d});
    check({tag, "_stop_bits"}, {30'd0, bits[10:9]}, 32'd3);
    check({tag, "_idle_after"}, {30'd0, lb_tx, lb_tx_ready}, 32'd3);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] ra;
    bit         keep;

    reset       = 1'b1;
    tx_valid    = 1'b1;
    tx_data     = 8'h5A;
    lb_tx_valid = 1'b0;
    lb_tx_data  = 8'h00;

    // Reset held with tx_valid asserted
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_hold", {28'd0, tx, tx_ready, busy, baud}, 32'hC);
    end
    tx_valid = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {28'd0, tx, tx_ready, busy, baud}, 32'hC);
    repeat (2) @(negedge clk);
    check("idle_no_baud", {28'd0, tx, tx_ready, busy, baud}, 32'hC);

    run_frame("a5", 8'hA5, 1'b0, -1, 8'h00);
    repeat (3) @(negedge clk);

    run_frame("b2b_00", 8'h00, 1'b1, -1, 8'h00);
    run_frame("b2b_ff", 8'hFF, 1'b0, -1, 8'h00);
    repeat (2) @(negedge clk);

    // Data changed during data bit 2 must not disturb the frame
    run_frame("c3_hold", 8'hC3, 1'b0, 13, 8'h00);
    @(negedge clk);

    // Reset pulsed during data bit 3
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_bit3_level", {31'd0, tx}, {31'd0, line_bit(8'h96, 17)});
    #2 reset = 1'b1;
    #1;
    check("rst_async_line", {28'd0, tx, tx_ready, busy, baud}, 32'hC);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_abort_idle", {28'd0, tx, tx_ready, busy, baud}, 32'hC);
    run_frame("after_rst_5a", 8'h5A, 1'b0, -1, 8'h00);

    // Random bytes, random back-to-back, random mid-frame data changes
    for (int k = 0; k < 6; k++) begin
      rd   = 8'($urandom);
      ra   = 8'($urandom);
      keep = (k == 5) ? 1'b0 : 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", k), rd, keep, int'($urandom_range(0, FRAME - 1)), ra);
    end
    @(negedge clk);

    // Loopback at full rate with two stop bits
    lb_frame("lb_3c", 8'h3C);
    lb_frame("lb_00", 8'h00);
    lb_frame("lb_ff", 8'hFF);
    lb_frame("lb_rand", 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
